uart_rx_param: RTL and testbench

Parametrised UART receiver, the successor of the fixed 8N1 baud-clocked receiver. Runs on the system clock and derives an internal oversampling tick. Supports 5–9 data bits, optional odd/even parity and 1 or 2 stop bits. Validates the start bit, detects parity, framing and overrun errors, and presents each frame through a valid/ready handshake to the command parser.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tick_gen.sv | 33 +++
 rtl/uart_rx_param.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART blocks: parity modes, receiver
// state encoding and the oversampling divider calculation.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  localparam logic [2:0] ST_ESPERAR   = 3'd0;
  localparam logic [2:0] ST_INICIO    = 3'd1;
  localparam logic [2:0] ST_DATOS     = 3'd2;
  localparam logic [2:0] ST_PARIDAD   = 3'd3;
  localparam logic [2:0] ST_PARADA    = 3'd4;
  localparam logic [2:0] ST_RECUPERAR = 3'd5;

  // System clocks per oversampling tick, never below 1.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned d;
    d = clk_freq / (baud * os);
    if (d == 0) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversampling tick generator: one-clock tick every DIV clocks while enabled,
// counter parked at 0 and tick suppressed while disabled.
module uart_tick_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rstN,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap_c;

  assign wrap_c = (cnt == CW'(DIV - 1));

  // Divider counter and registered tick.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!enable) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= wrap_c;
      cnt  <= wrap_c ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled start-bit validation, 5..9 data
// bits LSB first, optional parity, 1 or 2 stop bits, valid/ready output with
// parity, framing and overrun reporting.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dato,
  output logic                 hecho,
  input  logic                 listo,
  output logic                 errParidad,
  output logic                 errTrama,
  output logic                 desborde
);

  localparam int unsigned DIV     = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned SW      = $clog2(OVERSAMPLE);
  localparam int unsigned BW      = 4;
  localparam logic        PAR_ODD = 1'(PARITY == PARITY_ODD);

  logic                 rx_meta, rx_s;
  logic [2:0]           state, state_nxt;
  logic [SW-1:0]        samp, samp_nxt;
  logic [BW-1:0]        bits, bits_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 perr, perr_nxt;
  logic                 ferr, ferr_nxt;
  logic                 tick, tick_en;
  logic                 mid_c, done_c;

  // Two-flop synchroniser on the asynchronous line, idle high.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick_en = (state != ST_ESPERAR);

  uart_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rstN   (rstN),
    .enable (tick_en),
    .tick   (tick)
  );

  assign mid_c = tick && (samp == SW'(OVERSAMPLE - 1));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state <= ST_ESPERAR;
      samp  <= '0;
      bits  <= '0;
      shreg <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      state <= state_nxt;
      samp  <= samp_nxt;
      bits  <= bits_nxt;
      shreg <= shreg_nxt;
      perr  <= perr_nxt;
      ferr  <= ferr_nxt;
    end
  end

  // Next-state, sampling and frame-completion decode.
  always_comb begin
    state_nxt = state;
    samp_nxt  = samp;
    bits_nxt  = bits;
    shreg_nxt = shreg;
    perr_nxt  = perr;
    ferr_nxt  = ferr;
    done_c    = 1'b0;
    case (state)
      ST_ESPERAR: begin
        if (!rx_s) begin
          state_nxt = ST_INICIO;
          samp_nxt  = '0;
        end
      end
      ST_INICIO: begin
        if (tick) begin
          if (samp == SW'(OVERSAMPLE / 2 - 1)) begin
            samp_nxt = '0;
            if (rx_s) begin
              state_nxt = ST_ESPERAR;
            end else begin
              state_nxt = ST_DATOS;
              bits_nxt  = '0;
              perr_nxt  = 1'b0;
              ferr_nxt  = 1'b0;
            end
          end else begin
            samp_nxt = samp + SW'(1);
          end
        end
      end
      ST_DATOS: begin
        if (tick) samp_nxt = mid_c ? '0 : samp + SW'(1);
        if (mid_c) begin
          shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
          if (bits == BW'(DATA_BITS - 1)) begin
            bits_nxt  = '0;
            state_nxt = (PARITY != PARITY_NONE) ? ST_PARIDAD : ST_PARADA;
          end else begin
            bits_nxt = bits + BW'(1);
          end
        end
      end
      ST_PARIDAD: begin
        if (tick) samp_nxt = mid_c ? '0 : samp + SW'(1);
        if (mid_c) begin
          perr_nxt  = (^shreg) ^ rx_s ^ PAR_ODD;
          bits_nxt  = '0;
          state_nxt = ST_PARADA;
        end
      end
      ST_PARADA: begin
        if (tick) samp_nxt = mid_c ? '0 : samp + SW'(1);
        if (mid_c) begin
          if (!rx_s) ferr_nxt = 1'b1;
          if (bits == BW'(STOP_BITS - 1)) begin
            done_c    = 1'b1;
            bits_nxt  = '0;
            state_nxt = rx_s ? ST_ESPERAR : ST_RECUPERAR;
          end else begin
            bits_nxt = bits + BW'(1);
          end
        end
      end
      ST_RECUPERAR: begin
        if (rx_s) state_nxt = ST_ESPERAR;
      end
      default: state_nxt = ST_ESPERAR;
    endcase
  end

  // Output word, flags and handshake; a completion while unread is dropped.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      dato       <= '0;
      hecho      <= 1'b0;
      errParidad <= 1'b0;
      errTrama   <= 1'b0;
      desborde   <= 1'b0;
    end else begin
      desborde <= 1'b0;
      if (done_c) begin
        if (!hecho || listo) begin
          dato       <= shreg;
          errParidad <= perr;
          errTrama   <= ferr_nxt;
          hecho      <= 1'b1;
        end else begin
          desborde <= 1'b1;
        end
      end else if (hecho && listo) begin
        hecho <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance at 115200/50 MHz and a
// 7-bit even-parity, two-stop instance on a fast divider.
module tb_uart_rx_param;

  localparam int BP8 = 27 * 16;
  localparam int BP7 = 2 * 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN;
  logic       rx8, rx7, listo8, listo7;
  logic [7:0] dato8;
  logic [6:0] dato7;
  logic       hecho8, errParidad8, errTrama8, desborde8;
  logic       hecho7, errParidad7, errTrama7, desborde7;

  uart_rx_param dut8 (
    .clk(clk), .rstN(rstN), .rx(rx8), .dato(dato8), .hecho(hecho8),
    .listo(listo8), .errParidad(errParidad8), .errTrama(errTrama8),
    .desborde(desborde8)
  );

  uart_rx_param #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(8),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
  ) dut7 (
    .clk(clk), .rstN(rstN), .rx(rx7), .dato(dato7), .hecho(hecho7),
    .listo(listo7), .errParidad(errParidad7), .errTrama(errTrama7),
    .desborde(desborde7)
  );

  int vectors = 0;
  int miscompares = 0;

  // Frame monitors: count hecho rising edges, high cycles and overrun pulses.
  int         n8 = 0, hi8 = 0, ov8 = 0, n7 = 0, ov7 = 0;
  logic       hq8 = 1'b0, hq7 = 1'b0;
  logic [7:0] cap_dato8 = '0;
  logic [6:0] cap_dato7 = '0;
  logic       cap_par8 = 1'b0, cap_fr8 = 1'b0, cap_par7 = 1'b0, cap_fr7 = 1'b0;

  always @(negedge clk) begin
    hq8 <= hecho8;
    hq7 <= hecho7;
    if (hecho8) hi8 <= hi8 + 1;
    if (desborde8) ov8 <= ov8 + 1;
    if (desborde7) ov7 <= ov7 + 1;
    if (hecho8 && !hq8) begin
      n8        <= n8 + 1;
      cap_dato8 <= dato8;
      cap_par8  <= errParidad8;
      cap_fr8   <= errTrama8;
    end
    if (hecho7 && !hq7) begin
      n7        <= n7 + 1;
      cap_dato7 <= dato7;
      cap_par7  <= errParidad7;
      cap_fr7   <= errTrama7;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit v, input int n);
    if (sel) rx7 = v;
    else     rx8 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                            input bit par_en, input bit par_bit,
                            input bit stop_val, input int nstop);
    int bp;
    bp = sel ? BP7 : BP8;
    drive(sel, 1'b0, bp);
    for (int i = 0; i < nbits; i++) drive(sel, data[i], bp);
    if (par_en) drive(sel, par_bit, bp);
    for (int i = 0; i < nstop; i++) drive(sel, stop_val, bp);
    if (stop_val) drive(sel, 1'b1, 2 * bp);
  endtask

  int b, h, o;

  initial begin
    rstN = 1'b0; rx8 = 1'b1; rx7 = 1'b1; listo8 = 1'b1; listo7 = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_hecho8", 32'(hecho8), 32'd0);
    chk("rst_dato8", 32'(dato8), 32'd0);
    chk("rst_par8", 32'(errParidad8), 32'd0);
    chk("rst_trama8", 32'(errTrama8), 32'd0);
    chk("rst_desborde8", 32'(desborde8), 32'd0);
    chk("rst_hecho7", 32'(hecho7), 32'd0);
    rstN = 1'b1;
    repeat (10) @(negedge clk);

    // 8N1 clean frame with consumer ready
    b = n8; h = hi8;
    send_frame(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1);
    chk("t1_count", 32'(n8 - b), 32'd1);
    chk("t1_dato", 32'(cap_dato8), 32'hA5);
    chk("t1_par", 32'(cap_par8), 32'd0);
    chk("t1_trama", 32'(cap_fr8), 32'd0);
    chk("t1_pulse_len", 32'(hi8 - h), 32'd1);

    // 7-bit even parity: 0x41 has two ones, so parity bit 0 is correct
    b = n7;
    send_frame(1'b1, 9'h041, 7, 1'b1, 1'b0, 1'b1, 2);
    chk("t2_good_count", 32'(n7 - b), 32'd1);
    chk("t2_good_dato", 32'(cap_dato7), 32'h41);
    chk("t2_good_par", 32'(cap_par7), 32'd0);
    chk("t2_good_trama", 32'(cap_fr7), 32'd0);
    b = n7;
    send_frame(1'b1, 9'h041, 7, 1'b1, 1'b1, 1'b1, 2);
    chk("t2_bad_count", 32'(n7 - b), 32'd1);
    chk("t2_bad_dato", 32'(cap_dato7), 32'h41);
    chk("t2_bad_par", 32'(cap_par7), 32'd1);
    chk("t2_no_overrun", 32'(ov7), 32'd0);

    // Framing error, line held low, then recovery
    b = n8;
    send_frame(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 1);
    chk("t3_count", 32'(n8 - b), 32'd1);
    chk("t3_dato", 32'(cap_dato8), 32'h3C);
    chk("t3_trama", 32'(cap_fr8), 32'd1);
    drive(1'b0, 1'b0, 5 * BP8);
    drive(1'b0, 1'b1, 2 * BP8);
    chk("t3_no_false_start", 32'(n8 - b), 32'd1);
    b = n8;
    send_frame(1'b0, 9'h055, 8, 1'b0, 1'b0, 1'b1, 1);
    chk("t3_next_count", 32'(n8 - b), 32'd1);
    chk("t3_next_dato", 32'(cap_dato8), 32'h55);
    chk("t3_next_trama", 32'(cap_fr8), 32'd0);

    // Short glitch of a quarter bit is rejected
    b = n8;
    drive(1'b0, 1'b0, BP8 / 4);
    drive(1'b0, 1'b1, 3 * BP8);
    chk("t4_glitch", 32'(n8 - b), 32'd0);
    send_frame(1'b0, 9'h012, 8, 1'b0, 1'b0, 1'b1, 1);
    chk("t4_count", 32'(n8 - b), 32'd1);
    chk("t4_dato", 32'(cap_dato8), 32'h12);

    // Overrun with consumer stalled
    listo8 = 1'b0;
    b = n8; o = ov8;
    send_frame(1'b0, 9'h011, 8, 1'b0, 1'b0, 1'b1, 1);
    chk("t5_hecho_held", 32'(hecho8), 32'd1);
    chk("t5_dato_first", 32'(dato8), 32'h11);
    send_frame(1'b0, 9'h022, 8, 1'b0, 1'b0, 1'b1, 1);
    chk("t5_desborde", 32'(ov8 - o), 32'd1);
    chk("t5_dato_kept", 32'(dato8), 32'h11);
    chk("t5_hecho_still", 32'(hecho8), 32'd1);
    chk("t5_one_rise", 32'(n8 - b), 32'd1);
    listo8 = 1'b1;
    @(negedge clk);
    chk("t5_hecho_drop", 32'(hecho8), 32'd0);
    chk("t5_dato_hold", 32'(dato8), 32'h11);

    // Reset during data bit 4 aborts the frame
    b = n8;
    drive(1'b0, 1'b0, BP8);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'(i % 2), BP8);
    drive(1'b0, 1'b0, BP8 / 2);
    rstN = 1'b0;
    rx8  = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_rst_hecho", 32'(hecho8), 32'd0);
    chk("t6_rst_dato", 32'(dato8), 32'd0);
    chk("t6_rst_trama", 32'(errTrama8), 32'd0);
    rstN = 1'b1;
    drive(1'b0, 1'b1, 12 * BP8);
    chk("t6_no_partial", 32'(n8 - b), 32'd0);
    send_frame(1'b0, 9'h07E, 8, 1'b0, 1'b0, 1'b1, 1);
    chk("t6_count", 32'(n8 - b), 32'd1);
    chk("t6_dato", 32'(cap_dato8), 32'h7E);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
